// File: rtl/seq_controller.sv
// VeriRISC 8-phase instruction sequencer: decodes the opcode and the accumulator
// zero flag into per-phase strobes for the PC, IR, AC, memory and address mux.
module seq_controller #(
   parameter bit HALT_STICKY = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] opcode,
   input  logic       zero,
   output logic       sel,
   output logic       rd,
   output logic       ld_ir,
   output logic       inc_pc,
   output logic       ld_pc,
   output logic       halt,
   output logic       data_e,
   output logic       ld_ac,
   output logic       wr,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      INST_ADDR  = 3'd0,
      INST_FETCH = 3'd1,
      INST_LOAD  = 3'd2,
      IDLE       = 3'd3,
      OP_ADDR    = 3'd4,
      OP_FETCH   = 3'd5,
      ALU_OP     = 3'd6,
      STORE      = 3'd7
   } phase_e;

   localparam logic [2:0] OP_HLT = 3'd0;
   localparam logic [2:0] OP_SKZ = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_LDA = 3'd5;
   localparam logic [2:0] OP_STO = 3'd6;
   localparam logic [2:0] OP_JMP = 3'd7;

   phase_e phase_q, phase_d;
   logic   halted_q, halted_d;
   logic   aluop;

   // Halted freezes the phase; with HALT_STICKY=0 halted never sets.
   always_comb begin
      phase_d  = halted_q ? phase_q : phase_e'(3'(phase_q + 3'd1));
      halted_d = halted_q | (HALT_STICKY && (phase_q == OP_ADDR) && (opcode == OP_HLT));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q  <= INST_ADDR;
         halted_q <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         halted_q <= halted_d;
      end
   end

   assign aluop = (opcode == OP_ADD) | (opcode == OP_AND) |
                  (opcode == OP_XOR) | (opcode == OP_LDA);
   assign phase = phase_q;

   always_comb begin
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      halt   = 1'b0;
      data_e = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
      if (halted_q) begin
         halt = 1'b1;
      end else begin
         case (phase_q)
            INST_ADDR: sel = 1'b1;
            INST_FETCH: begin
               sel = 1'b1;
               rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
               sel   = 1'b1;
               rd    = 1'b1;
               ld_ir = 1'b1;
            end
            OP_ADDR: begin
               inc_pc = 1'b1;
               halt   = (opcode == OP_HLT);
            end
            OP_FETCH: rd = aluop;
            ALU_OP: begin
               rd     = aluop;
               inc_pc = (opcode == OP_SKZ) & zero;
               ld_pc  = (opcode == OP_JMP);
               data_e = (opcode == OP_STO);
            end
            STORE: begin
               rd     = aluop;
               ld_ac  = aluop;
               ld_pc  = (opcode == OP_JMP);
               wr     = (opcode == OP_STO);
               data_e = (opcode == OP_STO);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_controller.sv
// Directed bench for seq_controller: per-phase strobe masks per opcode, sticky halt,
// and a non-sticky instance driven by the same inputs.
module tb_seq_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] opcode;
   logic       zero;
   logic       sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr;
   logic [2:0] phase;
   logic       sel1, rd1, ld_ir1, inc_pc1, ld_pc1, halt1, data_e1, ld_ac1, wr1;
   logic [2:0] phase1;

   int pass_cnt = 0;
   int tot_cnt  = 0;

   always #5 clk = ~clk;

   seq_controller #(.HALT_STICKY(1'b1)) u_dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
      .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
      .halt(halt), .data_e(data_e), .ld_ac(ld_ac), .wr(wr), .phase(phase));

   seq_controller #(.HALT_STICKY(1'b0)) u_pulse (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
      .sel(sel1), .rd(rd1), .ld_ir(ld_ir1), .inc_pc(inc_pc1), .ld_pc(ld_pc1),
      .halt(halt1), .data_e(data_e1), .ld_ac(ld_ac1), .wr(wr1), .phase(phase1));

   // Strobe vector order: sel rd ld_ir inc_pc ld_pc halt data_e ld_ac wr
   function automatic logic [8:0] obs();
      return {sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr};
   endfunction

   function automatic logic [8:0] expv(input logic [7:0] s, r, li, ip, lp, h, de, la, w,
                                       input int i);
      return {s[i], r[i], li[i], ip[i], lp[i], h[i], de[i], la[i], w[i]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; opcode = 3'd2; zero = 1'b0;
      tick(); tick();
      rst = 1'b0;
      repeat (5) tick();
      tot_cnt++;
      if (phase !== 3'd5) $display("FAIL reset_pre_phase got %0d want 5", phase);
      else pass_cnt++;
      rst = 1'b1;
      tick();
      tot_cnt++;
      if (phase !== 3'd0 || obs() !== 9'b1_0000_0000)
         $display("FAIL reset_state got phase=%0d strobes=%b want phase=0 strobes=100000000", phase, obs());
      else pass_cnt++;
      tick();
      rst = 1'b0;
      tot_cnt++;
      if (phase !== 3'd0 || phase1 !== 3'd0 || obs() !== 9'b1_0000_0000)
         $display("FAIL reset_hold got phase=%0d/%0d strobes=%b", phase, phase1, obs());
      else pass_cnt++;
   endtask

   task automatic test_add();
      logic [8:0] e;
      opcode = 3'd2; zero = 1'b1;
      for (int i = 0; i < 8; i++) begin
         e = expv(8'h0F, 8'hEE, 8'h0C, 8'h10, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00, i);
         tot_cnt++;
         if (phase !== 3'(i) || obs() !== e)
            $display("FAIL add_p%0d got phase=%0d strobes=%b want phase=%0d strobes=%b", i, phase, obs(), i, e);
         else pass_cnt++;
         tick();
      end
      tot_cnt++;
      if (phase !== 3'd0) $display("FAIL add_wrap got %0d want 0", phase);
      else pass_cnt++;
   endtask

   task automatic test_skz();
      logic [8:0] e;
      opcode = 3'd1;
      for (int z = 1; z >= 0; z--) begin
         zero = z[0];
         for (int i = 0; i < 8; i++) begin
            e = expv(8'h0F, 8'h0E, 8'h0C, z ? 8'h50 : 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, i);
            tot_cnt++;
            if (phase !== 3'(i) || obs() !== e)
               $display("FAIL skz_z%0d_p%0d got phase=%0d strobes=%b want strobes=%b", z, i, phase, obs(), e);
            else pass_cnt++;
            tick();
         end
      end
   endtask

   task automatic test_jmp();
      logic [8:0] e;
      opcode = 3'd7; zero = 1'b1;
      for (int i = 0; i < 8; i++) begin
         e = expv(8'h0F, 8'h0E, 8'h0C, 8'h10, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, i);
         tot_cnt++;
         if (phase !== 3'(i) || obs() !== e)
            $display("FAIL jmp_p%0d got phase=%0d strobes=%b want strobes=%b", i, phase, obs(), e);
         else pass_cnt++;
         tick();
      end
   endtask

   task automatic test_sto();
      logic [8:0] e;
      opcode = 3'd6; zero = 1'b0;
      for (int i = 0; i < 8; i++) begin
         e = expv(8'h0F, 8'h0E, 8'h0C, 8'h10, 8'h00, 8'h00, 8'hC0, 8'h00, 8'h80, i);
         tot_cnt++;
         if (phase !== 3'(i) || obs() !== e)
            $display("FAIL sto_p%0d got phase=%0d strobes=%b want strobes=%b", i, phase, obs(), e);
         else pass_cnt++;
         tick();
      end
   endtask

   // Mixed instruction stream; expected masks come from the hand-written per-opcode table.
   task automatic test_back_to_back();
      logic [2:0] ops [6] = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1};
      logic [7:0] m_rd, m_ip, m_lp, m_de, m_la, m_w;
      logic [8:0] e;
      for (int n = 0; n < 6; n++) begin
         opcode = ops[n]; zero = n[0];
         m_rd = 8'h0E; m_ip = 8'h10; m_lp = 8'h00; m_de = 8'h00; m_la = 8'h00; m_w = 8'h00;
         case (ops[n])
            3'd3, 3'd4, 3'd5: begin m_rd = 8'hEE; m_la = 8'h80; end
            3'd6: begin m_de = 8'hC0; m_w = 8'h80; end
            3'd7: m_lp = 8'hC0;
            3'd1: m_ip = zero ? 8'h50 : 8'h10;
            default: ;
         endcase
         for (int i = 0; i < 8; i++) begin
            e = expv(8'h0F, m_rd, 8'h0C, m_ip, m_lp, 8'h00, m_de, m_la, m_w, i);
            tot_cnt++;
            if (phase !== 3'(i) || obs() !== e || (inc_pc & ld_pc))
               $display("FAIL b2b_op%0d_p%0d got phase=%0d strobes=%b want strobes=%b", ops[n], i, phase, obs(), e);
            else pass_cnt++;
            tick();
         end
      end
   endtask

   task automatic test_halt();
      logic [8:0] e;
      logic [2:0] p1;
      opcode = 3'd0; zero = 1'b0;
      for (int i = 0; i < 5; i++) begin
         e = expv(8'h0F, 8'h0E, 8'h0C, 8'h10, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, i);
         tot_cnt++;
         if (phase !== 3'(i) || obs() !== e || halt1 !== (i == 4))
            $display("FAIL hlt_p%0d got phase=%0d strobes=%b halt_pulse=%b want strobes=%b", i, phase, obs(), halt1, e);
         else pass_cnt++;
         tick();
      end
      for (int k = 0; k < 20; k++) begin
         if (k == 10) begin opcode = 3'd2; zero = 1'b1; end
         p1 = 3'((5 + k) % 8);
         tot_cnt++;
         if (phase !== 3'd5 || obs() !== 9'b0_0000_1000)
            $display("FAIL halted_k%0d got phase=%0d strobes=%b want phase=5 strobes=000001000", k, phase, obs());
         else pass_cnt++;
         tot_cnt++;
         if (phase1 !== p1 || halt1 !== (p1 == 3'd4 && opcode == 3'd0))
            $display("FAIL pulse_k%0d got phase=%0d halt=%b want phase=%0d", k, phase1, halt1, p1);
         else pass_cnt++;
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tot_cnt++;
      if (phase !== 3'd0 || halt !== 1'b0 || sel !== 1'b1)
         $display("FAIL halt_clear got phase=%0d halt=%b sel=%b want 0/0/1", phase, halt, sel);
      else pass_cnt++;
      tick();
      tot_cnt++;
      if (phase !== 3'd1 || halt !== 1'b0)
         $display("FAIL halt_resume got phase=%0d halt=%b want 1/0", phase, halt);
      else pass_cnt++;
   endtask

   initial begin
      rst = 1'b1; opcode = 3'd0; zero = 1'b0;
      #1;
      test_reset();
      test_add();
      test_skz();
      test_jmp();
      test_sto();
      test_back_to_back();
      test_halt();
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
